freq_offset_estimator: RTL and testbench

//  Parametrised successor to freq_correction. Takes a baseband I/Q sample stream and estimates

---
 rtl/freq_pkg.sv | 18 +
 rtl/iq_cross_product.sv | 41 ++++
 rtl/freq_offset_estimator.sv | 162 ++++++++++++++++
 tb/tb_freq_offset_estimator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the carrier frequency offset estimator:
// LO steering encodings, FSM state type and accumulator width helper.
package freq_pkg;

    localparam logic [1:0] FM_HOLD  = 2'b00;
    localparam logic [1:0] FM_RAISE = 2'b01;
    localparam logic [1:0] FM_LOWER = 2'b10;

    typedef enum logic {
        PRIME,
        ACCUM
    } state_t;

    function automatic int acc_width(input int iq_w, input int window);
        return 2 * iq_w + 1 + $clog2(window);
    endfunction

endpackage

// File: rtl/iq_cross_product.sv
// Registered phase-rotation cross product I[n-1]*Q[n] - Q[n-1]*I[n].
// A flush drops any in-flight product.
module iq_cross_product #(
    parameter int IQ_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   fire,
    input  logic signed [IQ_W-1:0] prev_i,
    input  logic signed [IQ_W-1:0] prev_q,
    input  logic signed [IQ_W-1:0] cur_i,
    input  logic signed [IQ_W-1:0] cur_q,
    output logic                   prod_valid,
    output logic signed [2*IQ_W:0] product
);

    logic signed [2*IQ_W-1:0] m_iq;
    logic signed [2*IQ_W-1:0] m_qi;
    logic signed [2*IQ_W:0]   diff;

    assign m_iq = prev_i * cur_q;
    assign m_qi = prev_q * cur_i;
    assign diff = {m_iq[2*IQ_W-1], m_iq} - {m_qi[2*IQ_W-1], m_qi};

    // stage 1: capture the product whenever a new sample pair fires
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_valid <= 1'b0;
            product    <= '0;
        end else if (flush) begin
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= fire;
            if (fire) begin
                product <= diff;
            end
        end
    end

endmodule

// File: rtl/freq_offset_estimator.sv
// Carrier frequency offset estimator: windowed I/Q cross-product
// accumulation with hysteresis-filtered LO steering and lock flag.
module freq_offset_estimator
    import freq_pkg::*;
#(
    parameter int IQ_W   = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 64,
    parameter int CONSEC = 2
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      en,
    input  logic                                      in_valid,
    input  logic signed [IQ_W-1:0]                    in_phase,
    input  logic signed [IQ_W-1:0]                    quad_phase,
    output logic [1:0]                                freq_mod,
    output logic signed [acc_width(IQ_W, WINDOW)-1:0] freq_err,
    output logic                                      err_valid,
    output logic                                      locked
);

    localparam int ACC_W  = acc_width(IQ_W, WINDOW);
    localparam int PROD_W = 2 * IQ_W + 1;
    localparam int CNT_W  = $clog2(WINDOW);
    localparam int RUN_W  = $clog2(CONSEC + 1);

    localparam logic signed [ACC_W-1:0] POS_T = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] NEG_T = ACC_W'(-THRESH);
    localparam logic [CNT_W-1:0]        LAST  = CNT_W'(WINDOW - 1);
    localparam logic [RUN_W-1:0]        SAT   = RUN_W'(CONSEC);

    state_t                   state;
    state_t                   state_nxt;
    logic                     fire;
    logic signed [IQ_W-1:0]   prev_i;
    logic signed [IQ_W-1:0]   prev_q;
    logic                     prod_valid;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic                     win_done;
    logic [1:0]               cls;
    logic [1:0]               last_cls;
    logic [RUN_W-1:0]         run;
    logic [RUN_W-1:0]         run_nxt;

    // prime/accumulate state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    // next state; a product fires only once a previous sample exists
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        if (!en) begin
            state_nxt = PRIME;
        end else begin
            unique case (state)
                PRIME: if (in_valid) state_nxt = ACCUM;
                ACCUM: fire = in_valid;
                default: state_nxt = PRIME;
            endcase
        end
    end

    // previous sample, kept across window boundaries
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_i <= '0;
            prev_q <= '0;
        end else if (en && in_valid) begin
            prev_i <= in_phase;
            prev_q <= quad_phase;
        end
    end

    iq_cross_product #(
        .IQ_W(IQ_W)
    ) u_xprod (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (!en),
        .fire      (fire),
        .prev_i    (prev_i),
        .prev_q    (prev_q),
        .cur_i     (in_phase),
        .cur_q     (quad_phase),
        .prod_valid(prod_valid),
        .product   (product)
    );

    assign prod_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};

    // stage 2: window accumulator; first product of a window loads
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc      <= '0;
            cnt      <= '0;
            win_done <= 1'b0;
        end else if (!en) begin
            acc      <= '0;
            cnt      <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= prod_valid && (cnt == LAST);
            if (prod_valid) begin
                acc <= (cnt == '0) ? prod_ext : acc + prod_ext;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // classify the completed window and advance the run counter
    always_comb begin
        cls = FM_HOLD;
        if (acc > POS_T) begin
            cls = FM_RAISE;
        end else if (acc < NEG_T) begin
            cls = FM_LOWER;
        end
        run_nxt = RUN_W'(1);
        if (cls == last_cls && run != '0) begin
            run_nxt = (run == SAT) ? run : run + 1'b1;
        end
    end

    // stage 3: publish the estimate and apply hysteresis
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            freq_err  <= '0;
            err_valid <= 1'b0;
            freq_mod  <= FM_HOLD;
            locked    <= 1'b0;
            last_cls  <= FM_HOLD;
            run       <= '0;
        end else begin
            err_valid <= win_done;
            if (win_done) begin
                freq_err <= acc;
                last_cls <= cls;
                run      <= run_nxt;
                if (cls != FM_HOLD) begin
                    locked <= 1'b0;
                end
                if (run_nxt == SAT) begin
                    freq_mod <= cls;
                    if (cls == FM_HOLD) begin
                        locked <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_offset_estimator.sv
// Directed bench for freq_offset_estimator: tones, constant input,
// enable drop and extreme-value windows with hand-computed results.
module tb_freq_offset_estimator;

    logic               clk = 1'b0;
    logic               resetn;
    logic               en;
    logic               in_valid;
    logic signed [7:0]  in_phase;
    logic signed [7:0]  quad_phase;
    logic [1:0]         freq_mod;
    logic signed [20:0] freq_err;
    logic               err_valid;
    logic               locked;

    int     total = 0;
    int     bad = 0;
    int     ev_cnt = 0;
    longint ev_err = 0;
    longint ev_mod = 0;
    longint ev_lock = 0;

    int tone_i[4] = '{100, 0, -100, 0};
    int tone_q[4] = '{0, 100, 0, -100};
    int rot_i[4]  = '{-128, 127, 127, -128};
    int rot_q[4]  = '{-128, -128, 127, 127};

    always #5 clk = ~clk;

    freq_offset_estimator #(
        .IQ_W  (8),
        .WINDOW(16),
        .THRESH(64),
        .CONSEC(2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .in_valid  (in_valid),
        .in_phase  (in_phase),
        .quad_phase(quad_phase),
        .freq_mod  (freq_mod),
        .freq_err  (freq_err),
        .err_valid (err_valid),
        .locked    (locked)
    );

    // record every estimate the DUT publishes
    always @(negedge clk) begin
        if (err_valid) begin
            ev_cnt  = ev_cnt + 1;
            ev_err  = freq_err;
            ev_mod  = freq_mod;
            ev_lock = locked;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // sel: 0 CCW tone, 1 CW tone, 2 constant, 3 alternating extremes,
    // 4 rotating extremes; one sample every third clock
    task automatic send_seq(input int sel, input int first, input int n);
        int si;
        int sq;
        for (int k = first; k < first + n; k++) begin
            si = 0;
            sq = 0;
            case (sel)
                0: begin si = tone_i[k % 4]; sq = tone_q[k % 4]; end
                1: begin si = tone_i[k % 4]; sq = -tone_q[k % 4]; end
                2: begin si = 100; sq = 0; end
                3: begin si = -128; sq = (k % 2 == 0) ? -128 : 127; end
                default: begin si = rot_i[k % 4]; sq = rot_q[k % 4]; end
            endcase
            @(negedge clk);
            in_valid   = 1'b1;
            in_phase   = 8'(si);
            quad_phase = 8'(sq);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_ev(input string tag, input int n);
        for (int i = 0; i < 40 && ev_cnt < n; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        chk(tag, ev_cnt, n);
    endtask

    task automatic chk_ev(input string tag, input longint err,
                          input longint fm, input longint lk);
        chk({tag, "_err"}, ev_err, err);
        chk({tag, "_mod"}, ev_mod, fm);
        chk({tag, "_lock"}, ev_lock, lk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        en         = 1'b0;
        in_valid   = 1'b0;
        in_phase   = '0;
        quad_phase = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mod", freq_mod, 0);
        chk("rst_err", freq_err, 0);
        chk("rst_ev", err_valid, 0);
        chk("rst_lock", locked, 0);
        resetn = 1'b1;
        en     = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_mod", freq_mod, 0);
        chk("idle_err", freq_err, 0);
        chk("idle_lock", locked, 0);
        chk("idle_ev", ev_cnt, 0);

        send_seq(0, 0, 17);
        wait_ev("ccw1_n", 1);
        chk_ev("ccw1", 160000, 0, 0);
        send_seq(0, 17, 16);
        wait_ev("ccw2_n", 2);
        chk_ev("ccw2", 160000, 1, 0);

        send_seq(2, 0, 16);
        wait_ev("dc1_n", 3);
        chk_ev("dc1", 0, 1, 0);
        send_seq(2, 0, 16);
        wait_ev("dc2_n", 4);
        chk_ev("dc2", 0, 0, 1);

        send_seq(1, 1, 16);
        wait_ev("cw1_n", 5);
        chk_ev("cw1", -160000, 0, 0);
        send_seq(1, 17, 16);
        wait_ev("cw2_n", 6);
        chk_ev("cw2", -160000, 2, 0);

        send_seq(1, 1, 7);
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("drop_n", ev_cnt, 6);
        chk("drop_mod", freq_mod, 2);
        chk("drop_err", freq_err, -160000);
        en = 1'b1;
        send_seq(1, 0, 17);
        wait_ev("reen_n", 7);
        chk_ev("reen", -160000, 2, 0);
        repeat (10) @(negedge clk);
        chk("reen_once", ev_cnt, 7);

        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        send_seq(3, 0, 17);
        wait_ev("alt_n", 8);
        chk_ev("alt", 0, 2, 0);
        send_seq(4, 1, 16);
        wait_ev("rot_n", 9);
        chk_ev("rot", 520200, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
